// File: rtl/alu32_issue.sv
// alu32_issue
// Operand-issue stage that sits directly upstream of a 32-bit combinational ALU.
// Commands {op, a, b, ci} arrive over a valid/ready handshake and are buffered
// in a DEPTH-entry FIFO. The FIFO head drives the ALU inputs combinationally,
// and the ALU result is captured into a handshaked output register together
// with carry, zero and illegal-op flags. Results leave in acceptance order.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   command handshake (in_ready = FIFO not full)
//   in_op/a/b/ci     command fields (op: 0 XOR, 1 ADD, 2 AND, 3 OR, 4 NOT a, 5-7 illegal)
//   alu_in1/in2/ci/a FIFO head presented to the ALU (all zero while empty)
//   alu_cout/alu_co  ALU result and adder carry-out
//   out_valid/ready  result handshake
//   out_result/co/zero/illegal  registered result and flags
//   count            FIFO occupancy
module alu32_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_ci,
  output logic [31:0]              alu_in1,
  output logic [31:0]              alu_in2,
  output logic                     alu_ci,
  output logic [2:0]               alu_a,
  input  logic [31:0]              alu_cout,
  input  logic                     alu_co,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_co,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [2:0]    OP_ADD   = 3'd1;
  localparam logic [2:0]    OP_ILL   = 3'd5;

  // Ops 5..7 have no ALU function; they still produce a (zero) result.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op >= OP_ILL);
  endfunction

  logic [2:0]    fifo_op [DEPTH];
  logic [31:0]   fifo_a  [DEPTH];
  logic [31:0]   fifo_b  [DEPTH];
  logic          fifo_ci [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic       head_valid;
  logic       push;
  logic       pop;
  logic [2:0] head_op;

  // in_ready depends on the registered count only, never on out_ready.
  assign in_ready   = (count != CNT_FULL);
  assign head_valid = (count != CNT_ZERO);
  assign push       = in_valid && in_ready;
  assign pop        = head_valid && (!out_valid || out_ready);
  assign head_op    = fifo_op[rd_ptr];

  // Present the FIFO head to the ALU, forcing zeros while the FIFO is empty.
  always_comb begin
    alu_in1 = 32'd0;
    alu_in2 = 32'd0;
    alu_ci  = 1'b0;
    alu_a   = 3'd0;
    if (head_valid) begin
      alu_in1 = fifo_a[rd_ptr];
      alu_in2 = fifo_b[rd_ptr];
      alu_ci  = fifo_ci[rd_ptr];
      alu_a   = head_op;
    end else begin
      alu_in1 = 32'd0;
      alu_in2 = 32'd0;
      alu_ci  = 1'b0;
      alu_a   = 3'd0;
    end
  end

  // Command storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= in_op;
      fifo_a[wr_ptr]  <= in_a;
      fifo_b[wr_ptr]  <= in_b;
      fifo_ci[wr_ptr] <= in_ci;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Result register: load on issue, clear valid on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_co      <= 1'b0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_result  <= alu_cout;
      out_co      <= (head_op == OP_ADD) ? alu_co : 1'b0;
      out_zero    <= (alu_cout == 32'd0);
      out_illegal <= op_is_illegal(head_op);
    end else if (out_valid && out_ready) begin
      // Nothing to issue: the result is consumed, flags keep their last values.
      out_valid   <= 1'b0;
    end else begin
      out_valid   <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu32_issue.sv
module tb_alu32_issue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ci;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_ci;
  logic [2:0]  alu_a;
  logic [31:0] alu_cout;
  logic        alu_co;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_co;
  logic        out_zero;
  logic        out_illegal;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  alu32_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_a(alu_a),
    .alu_cout(alu_cout), .alu_co(alu_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_co(out_co), .out_zero(out_zero), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  // Architectural result of one command.
  function automatic logic [31:0] ref_result(input cmd_t c);
    case (c.op)
      3'd0:    return c.a ^ c.b;
      3'd1:    return c.a + c.b + {31'd0, c.ci};
      3'd2:    return c.a & c.b;
      3'd3:    return c.a | c.b;
      3'd4:    return ~c.a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic add_carry(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    return s[32];
  endfunction

  // Stand-in ALU; carry-out is always the adder carry so the op==ADD masking is exercised.
  always_comb begin
    cmd_t c;
    c = '{op: alu_a, a: alu_in1, b: alu_in2, ci: alu_ci};
    alu_cout = ref_result(c);
    alu_co   = add_carry(alu_in1, alu_in2, alu_ci);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted commands plus the output register.
  cmd_t        q[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_co = 1'b0;
  logic        m_zero = 1'b0;
  logic        m_ill = 1'b0;
  logic        started = 1'b0;

  always @(posedge clk) begin : model
    cmd_t c;
    logic push_ok;
    logic pop_ok;
    started <= 1'b1;
    if (rst) begin
      q.delete();
      m_valid <= 1'b0;
      m_res   <= 32'd0;
      m_co    <= 1'b0;
      m_zero  <= 1'b0;
      m_ill   <= 1'b0;
    end else begin
      push_ok = in_valid && (q.size() < DEPTH);
      pop_ok  = (q.size() != 0) && (!m_valid || out_ready);
      if (pop_ok) begin
        c = q.pop_front();
        m_valid <= 1'b1;
        m_res   <= ref_result(c);
        m_co    <= (c.op == 3'd1) ? add_carry(c.a, c.b, c.ci) : 1'b0;
        m_zero  <= (ref_result(c) == 32'd0);
        m_ill   <= (c.op >= 3'd5);
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (push_ok) begin
        q.push_back('{op: in_op, a: in_a, b: in_b, ci: in_ci});
      end
    end
  end

  // Compare every observable output against the model each cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("count",       32'(count), 32'(q.size()));
      chk("in_ready",    32'(in_ready), 32'(q.size() != DEPTH));
      chk("out_valid",   32'(out_valid), 32'(m_valid));
      chk("out_result",  out_result, m_res);
      chk("out_co",      32'(out_co), 32'(m_co));
      chk("out_zero",    32'(out_zero), 32'(m_zero));
      chk("out_illegal", 32'(out_illegal), 32'(m_ill));
      chk("alu_in1",     alu_in1, (q.size() != 0) ? q[0].a : 32'd0);
      chk("alu_in2",     alu_in2, (q.size() != 0) ? q[0].b : 32'd0);
      chk("alu_ci",      32'(alu_ci), (q.size() != 0) ? 32'(q[0].ci) : 32'd0);
      chk("alu_a",       32'(alu_a), (q.size() != 0) ? 32'(q[0].op) : 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ci);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [2:0]  ms_op [4];
  logic [31:0] ms_exp [4];

  initial begin
    ms_op[0] = 3'd0; ms_exp[0] = 32'h0FF0_0FF0;
    ms_op[1] = 3'd2; ms_exp[1] = 32'hF000_F000;
    ms_op[2] = 3'd3; ms_exp[2] = 32'hFFF0_FFF0;
    ms_op[3] = 3'd4; ms_exp[3] = 32'hFFFF_0000;

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    rst = 1'b0;

    // Single ADD with carry out and zero result.
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'd0);
    chk("add_co", 32'(out_co), 32'd1);
    chk("add_zero", 32'(out_zero), 32'd1);
    chk("add_illegal", 32'(out_illegal), 32'd0);

    // Mixed logic ops back to back; results appear two cycles after drive.
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        chk("mix_valid", 32'(out_valid), 32'd1);
        chk("mix_result", out_result, ms_exp[i-2]);
        chk("mix_co", 32'(out_co), 32'd0);
      end
      if (i < 4) drive(1'b1, ms_op[i], (i == 3) ? 32'h0000_FFFF : 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
      else       drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
    end

    // Backpressure until full: one result held plus DEPTH buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'($urandom_range(0, 4)), $urandom(), $urandom(), 1'($urandom()));
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Steady push and pop at count == 2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, $urandom(), $urandom(), 1'($urandom()));
      @(negedge clk);
    end
    chk("pp_start_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'($urandom_range(0, 4)), $urandom(), $urandom(), 1'($urandom()));
      @(negedge clk);
      chk("pp_count", 32'(count), 32'd2);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);

    // Illegal op 6.
    drive(1'b1, 3'd6, 32'h1234_5678, 32'h0000_0001, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("ill_result", out_result, 32'd0);
    chk("ill_zero", 32'(out_zero), 32'd1);
    chk("ill_illegal", 32'(out_illegal), 32'd1);
    chk("ill_co", 32'(out_co), 32'd0);
    repeat (2) @(negedge clk);

    // Reset mid-stream discards buffered commands and the pending result.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd3, $urandom(), $urandom(), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            rnd_word(), rnd_word(), 1'($urandom()));
      out_ready = (i % 200 < 30) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("final_count", 32'(count), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
